led_trail_pwm: RTL

Downstream output stage for the LED pattern generators, such as the scanning "bouncing dot" driver. It takes the raw 8-bit LED pattern and drives the board LEDs through per-channel PWM. Each lit position snaps to full brightness, then fades out linearly once the pattern moves away, producing a decaying trail. It sits between the pattern generator and the top-level leds pins.

---
 rtl/led_trail_pwm.sv | 109 ++++++++++
 1 files changed

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: per-channel PWM output stage with a decaying trail.
// A lit pattern bit snaps its channel to full brightness; once the bit drops,
// the channel level fades linearly by DECAY_STEP every DECAY_DIV clocks.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   enable       1 = run, 0 = freeze all state and blank outputs
//   pattern_in   raw LED pattern (bit i high = position i lit)
//   leds         registered PWM drive, one bit per channel
//   frame_start  registered one-cycle pulse while pwm counter sits at 0 after a wrap
//
// Build option: define LED_TRAIL_GAMMA_EN to compare against a registered
// square-law level (adds one pipeline stage, pattern->leds latency 3 clocks).
module led_trail_pwm #(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 50_000,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_LEDS-1:0] pattern_in,
  output logic [NUM_LEDS-1:0] leds,
  output logic                frame_start
);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam int                  PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0]                pwm_q, pwm_d;
  logic [PRE_W-1:0]                   pre_q, pre_d;
  logic                               decay_tick;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_q, level_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  cmp_lvl, cmp_val;
  logic [NUM_LEDS-1:0]                leds_q, leds_d;
  logic                               fs_q;

  always_comb begin
    pwm_d      = pwm_q + 1'b1;
    decay_tick = (pre_q == PRE_LAST);
    pre_d      = decay_tick ? '0 : pre_q + 1'b1;
  end

`ifdef LED_TRAIL_GAMMA_EN
  // Raw level is delayed alongside the square so the full-on/zero overrides
  // stay aligned with the gamma value they accompany.
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] lvl_p_q, g_q, g_d;
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
    always_comb begin
      level_d[i] = level_q[i];
      if (pattern_in[i])   level_d[i] = LVL_MAX;
      else if (decay_tick) level_d[i] = (level_q[i] < STEP) ? '0 : level_q[i] - STEP;
    end

`ifdef LED_TRAIL_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    assign sq         = (2*PWM_BITS)'(level_q[i]) * (2*PWM_BITS)'(level_q[i]);
    assign g_d[i]     = sq[2*PWM_BITS-1:PWM_BITS];
    assign cmp_lvl[i] = lvl_p_q[i];
    assign cmp_val[i] = g_q[i];
`else
    assign cmp_lvl[i] = level_q[i];
    assign cmp_val[i] = level_q[i];
`endif

    // Full scale is a hard on; otherwise duty is cmp_val / 2^PWM_BITS.
    assign leds_d[i] = (cmp_lvl[i] == LVL_MAX) ||
                       ((cmp_lvl[i] != '0) && (cmp_val[i] > pwm_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q   <= '0;
      pre_q   <= '0;
      level_q <= '0;
      leds_q  <= '0;
      fs_q    <= 1'b0;
    end else if (enable) begin
      pwm_q   <= pwm_d;
      pre_q   <= pre_d;
      level_q <= level_d;
      leds_q  <= leds_d;
      fs_q    <= (pwm_q == LVL_MAX);
    end else begin
      leds_q  <= '0;
      fs_q    <= 1'b0;
    end
  end

`ifdef LED_TRAIL_GAMMA_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_p_q <= '0;
      g_q     <= '0;
    end else if (enable) begin
      lvl_p_q <= level_q;
      g_q     <= g_d;
    end
  end
`endif

  assign leds        = leds_q;
  assign frame_start = fs_q;
endmodule
